// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, default reset PC and instruction width.
package core_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding {pc, instruction} pairs between fetch and decode.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DATA_W = 2 * INSTR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding imem request, 2-entry decode buffer, redirect flush.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fault and halts fetch.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_instruction,
    input  logic        d_ready,
    output logic        fault
);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_addr;
    logic [31:0]  redir_target;
    logic         issue;
    logic         push;
    logic         pop;
    logic         halted;
    logic [1:0]   count;
    logic [63:0]  head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    assign redir_target = redirect_pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fault_q <= 1'b0;
        else if (redirect && (redirect_pc[1:0] != 2'b00))
            fault_q <= 1'b1;
    end

    assign fault  = fault_q;
    assign halted = fault_q;
`else
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
    assign fault        = 1'b0;
    assign halted       = 1'b0;
`endif

    // The request stays up through DROP so the bus sees a stable handshake until ack.
    assign imem_req  = (state != IDLE);
    assign imem_addr = req_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered occupancy is used for issue, so an in-flight fetch always has a free slot.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && !halted && (count < 2'd2)) begin
                    state_nxt = REQ;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                    push      = !redirect;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect)  fetch_pc <= redir_target;
            else if (push) fetch_pc <= req_addr + 32'd4;
            if (issue)     req_addr <= fetch_pc;
        end
    end

    assign pop = d_valid && d_ready && !redirect;

    fetch_buffer #(
        .DATA_W (2 * INSTR_W)
    ) u_fetch_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({req_addr, imem_rdata}),
        .head_data (head),
        .count     (count)
    );

    assign d_valid       = (count != 2'd0);
    assign d_pc          = head[63:32];
    assign d_instruction = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-programmable instruction memory responder.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instruction;
    logic        d_ready;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          pop_cnt = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_e;
    logic [31:0] model_pc;
    logic        drop_pending;
    logic        model_halt;
    logic        acking;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .d_valid       (d_valid),
        .d_pc          (d_pc),
        .d_instruction (d_instruction),
        .d_ready       (d_ready),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Memory responder, pop monitor and expected-stream model, all evaluated mid-cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            imem_ack     = 1'b0;
            imem_rdata   = 32'h0;
            wait_cnt     = 0;
            sb_q.delete();
            model_pc     = RST_PC;
            drop_pending = 1'b0;
            model_halt   = 1'b0;
        end else begin
            if (d_valid && d_ready && !redirect) begin
                pop_cnt++;
                if (sb_q.size() == 0) begin
                    check("sb_extra_pop", {31'b0, d_valid}, 32'h0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_pc", d_pc, sb_e[63:32]);
                    check("sb_instr", d_instruction, sb_e[31:0]);
                end
            end
            acking = imem_req && !imem_ack && (wait_cnt >= mem_lat);
            if (acking) begin
                if (!redirect && !drop_pending && !model_halt) begin
                    sb_q.push_back({model_pc, word_of(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                drop_pending = 1'b0;
            end
            if (redirect) begin
                sb_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                model_pc = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) model_halt = 1'b1;
`else
                model_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
                if (imem_req && !acking) drop_pending = 1'b1;
            end
            if (acking) begin
                imem_ack   = 1'b1;
                imem_rdata = word_of(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                if (imem_req) wait_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        for (int i = 0; i < 30; i++) begin
            if (imem_req == lvl) break;
            step();
        end
        check(tag, {31'b0, imem_req}, {31'b0, lvl});
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout act=%0d exp=0", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_addr;
        logic        seen;
        int          p0;

        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        d_ready     = 1'b1;
        repeat (3) step();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_dvalid", {31'b0, d_valid}, 32'h0);
        check("rst_dpc", d_pc, 32'h0);
        check("rst_dinstr", d_instruction, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);

        // Zero-wait fetch from reset with decode always ready.
        reset_n = 1'b1;
        step();
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, RST_PC);
        repeat (10) step();
        p0 = pop_cnt;
        repeat (20) step();
        check("throughput", pop_cnt - p0, 32'd10);

        // Reset mid-request, then stall decode until the buffer fills.
        mem_lat = 2;
        wait_req(1'b0, "pre_rst_idle");
        wait_req(1'b1, "pre_rst_req");
        reset_n = 1'b0;
        #1;
        check("rst_abandon", {31'b0, imem_req}, 32'h0);
        mem_lat = 0;
        d_ready = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (8) step();
        check("full_req_low", {31'b0, imem_req}, 32'h0);
        check("full_dvalid", {31'b0, d_valid}, 32'h1);
        check("full_dpc", d_pc, RST_PC);
        check("full_dinstr", d_instruction, word_of(RST_PC));
        repeat (2) step();
        check("hold_dpc", d_pc, RST_PC);
        d_ready = 1'b1;
        repeat (6) step();

        // Redirect coincident with ack.
        wait_req(1'b0, "d_idle");
        wait_req(1'b1, "d_req");
        do_redirect(32'h0000_2000);
        check("d_flush_req", {31'b0, imem_req}, 32'h0);
        check("d_flush_valid", {31'b0, d_valid}, 32'h0);
        step();
        check("d_req_new", {31'b0, imem_req}, 32'h1);
        check("d_addr_new", imem_addr, 32'h0000_2000);
        for (int i = 0; i < 10 && !d_valid; i++) step();
        check("d_dpc_new", d_pc, 32'h0000_2000);
        check("d_fault_low", {31'b0, fault}, 32'h0);

        // Redirect while a slow request is pending.
        wait_req(1'b0, "e_idle");
        mem_lat = 3;
        wait_req(1'b1, "e_req");
        old_addr = imem_addr;
        step();
        do_redirect(32'h0000_3000);
        check("e_drop_req", {31'b0, imem_req}, 32'h1);
        check("e_drop_addr", imem_addr, old_addr);
        check("e_drop_valid", {31'b0, d_valid}, 32'h0);
        wait_req(1'b0, "e_ack");
        step();
        check("e_req_new", {31'b0, imem_req}, 32'h1);
        check("e_addr_new", imem_addr, 32'h0000_3000);
        mem_lat = 0;
        repeat (8) step();

        // Address wrap.
        wait_req(1'b0, "f_idle");
        do_redirect(32'hFFFF_FFFC);
        wait_req(1'b1, "f_req0");
        check("f_addr_top", imem_addr, 32'hFFFF_FFFC);
        wait_req(1'b0, "f_gap");
        wait_req(1'b1, "f_req1");
        check("f_addr_wrap", imem_addr, 32'h0000_0000);
        repeat (6) step();

        // Misaligned redirect.
        wait_req(1'b0, "g_idle");
        do_redirect(32'h0000_2002);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("g_fault", {31'b0, fault}, 32'h1);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (imem_req) seen = 1'b1;
        end
        check("g_no_req", {31'b0, seen}, 32'h0);
        check("g_dvalid", {31'b0, d_valid}, 32'h0);
`else
        seen = 1'b0;
        wait_req(1'b1, "g_req");
        check("g_addr_aligned", imem_addr, 32'h0000_2000);
        check("g_fault_tied", {31'b0, fault | seen}, 32'h0);
        repeat (6) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  instruction-memory word address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch/JAL/JALR from execute.
- redirect_pc  in  32  redirect target.
- d_valid  out  1  PC/instruction pair offered to decode.
- d_pc  out  32  PC of offered instruction.
- d_instruction  out  32  offered instruction word.
- d_ready  in  1  decode accepts the pair.
- fault  out  1  misaligned redirect seen (see REQ-018).

Function
REQ-003 The block SHALL allow at most one outstanding memory request; imem_req and imem_addr SHALL remain stable from assertion until the cycle imem_ack is sampled high.
REQ-004 The block SHALL use states IDLE, REQ, DROP: IDLE->REQ when buffer has space; REQ->IDLE on ack; REQ->DROP on redirect without ack; DROP->IDLE on ack.
REQ-005 On imem_ack in REQ without redirect, the block SHALL push {imem_addr, imem_rdata} into a 2-entry FIFO and set the fetch PC to imem_addr+4, wrapping modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-006 A new request SHALL issue only when FIFO occupancy plus in-flight requests is below 2, so a push never meets a full FIFO.
REQ-007 d_valid SHALL equal FIFO not-empty; d_pc/d_instruction SHALL show the head entry; a pop SHALL occur on d_valid and d_ready in the same cycle.
REQ-008 Outputs d_pc and d_instruction SHALL hold stable while d_valid is high and d_ready is low.
REQ-009 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-010 On redirect, the block SHALL flush the FIFO (d_valid low next cycle) and load the fetch PC with redirect_pc.
REQ-011 Redirect coincident with imem_ack SHALL discard that data; the next request SHALL issue one cycle later at redirect_pc.
REQ-012 In DROP, the arriving ack data SHALL be discarded, then the redirect_pc request SHALL issue the following cycle; a second redirect during DROP SHALL replace the pending target.
REQ-013 Redirect SHALL take priority over d_ready pop in the same cycle.
REQ-014 With zero-wait memory (ack the cycle after req), d_valid SHALL rise one cycle after ack and sustained throughput SHALL be one instruction per two cycles.

Reset
REQ-015 While reset_n is low: imem_req=0, imem_addr=RESET_PC, d_valid=0, d_pc=0, d_instruction=0, fault=0, state IDLE, FIFO empty, fetch PC=RESET_PC.
REQ-016 The first request SHALL assert on the first rising edge after reset_n deasserts, with imem_addr=RESET_PC.
REQ-017 Reset asserted mid-request SHALL abandon it; a late imem_ack after reset SHALL be ignored unless a request is outstanding.

Configuration
REQ-018 Macro FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 SHALL set fault (sticky until reset), flush, and halt further requests.
REQ-019 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00 and fault tied to 0.

Structure
REQ-020 Shared package core_pkg SHALL hold the fetch-state enum, the default RESET_PC constant, and the instruction-width constant (32).
REQ-021 The FIFO SHALL be a sub-module fetch_buffer (2 entries, 64-bit payload, push/pop/flush, count output).

Verification
REQ-022 Reset release, RESET_PC=0x100, ack every second cycle, d_ready=1 -> d_pc sequence 0x100,0x104,0x108 with matching words.
REQ-023 d_ready=0 for 6 cycles -> exactly 2 entries buffered, imem_req low, d_pc=0x100 held; d_ready=1 -> 0x100,0x104 in order.
REQ-024 Redirect to 0x2000 with ack in same cycle -> data dropped, next imem_addr=0x2000, next d_pc=0x2000.
REQ-025 Redirect to 0x3000 while request pending 3 cycles -> DROP, late ack discarded, then imem_addr=0x3000.
REQ-026 Fetch at 0xFFFFFFFC -> following imem_addr=0x00000000.
REQ-027 With FETCH_MISALIGN_CHECK_EN, redirect to 0x2002 -> fault=1, no further imem_req; without it -> imem_addr=0x2000.
